// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port
// between two valid/ready producers, with bursts of up to MAX_BURST beats.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   req0_valid/_data/_ready  producer 0 handshake
//   req1_valid/_data/_ready  producer 1 handshake
//   fifo_full                FIFO full flag (stalls the current grant)
//   fifo_wr_en/_data_in      FIFO write port
//   grant                    registered one-hot grant (00 idle)
//   stats_clr, beat_cnt0/1   beat statistics, present only with ARB_STATS_EN
//
// Optional feature macro: ARB_STATS_EN (saturating per-producer beat counters).

module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
`ifdef ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  beat_cnt0,
    output logic [CNT_WIDTH-1:0]  beat_cnt1,
`endif
    output logic [1:0]            grant
);

    if (MAX_BURST < 1 || MAX_BURST > 16 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_write_arbiter: illegal parameter value");
    end

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        w_other;
    logic          r_last;
    logic          w_last_nxt;
    logic [BW-1:0] r_burst;
    logic [BW-1:0] w_burst_nxt;
    logic          w_own;
    logic          w_oth;
    logic          w_beat;
    logic          w_burst_end;

    // Valid of the granted producer and of the waiting one.
    always_comb begin
        w_own   = 1'b0;
        w_oth   = 1'b0;
        w_other = IDLE;
        case (r_state)
            GNT0: begin
                w_own   = req0_valid;
                w_oth   = req1_valid;
                w_other = GNT1;
            end
            GNT1: begin
                w_own   = req1_valid;
                w_oth   = req0_valid;
                w_other = GNT0;
            end
            default: ;
        endcase
    end

    assign w_beat      = w_own && !fifo_full;
    assign w_burst_end = (r_burst == LAST_BEAT);

    assign fifo_wr_en   = w_beat;
    assign req0_ready   = w_beat && (r_state == GNT0);
    assign req1_ready   = w_beat && (r_state == GNT1);
    assign fifo_data_in = !w_beat           ? '0 :
                          (r_state == GNT1) ? req1_data : req0_data;
    assign grant        = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        case (r_state)
            IDLE: begin
                // Tie goes to the producer not served most recently.
                if (req0_valid && req1_valid)
                    w_state_nxt = r_last ? GNT0 : GNT1;
                else if (req0_valid)
                    w_state_nxt = GNT0;
                else if (req1_valid)
                    w_state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!w_own) begin
                    // Granted producer ran dry: release the grant.
                    w_last_nxt  = (r_state == GNT1);
                    w_burst_nxt = '0;
                    w_state_nxt = w_oth ? w_other : IDLE;
                end else if (w_beat) begin
                    if (w_burst_end) begin
                        // Hand over without a bubble, or keep going
                        // if nobody else is waiting.
                        w_last_nxt  = (r_state == GNT1);
                        w_burst_nxt = '0;
                        w_state_nxt = w_oth ? w_other : r_state;
                    end else begin
                        w_burst_nxt = r_burst + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_burst <= w_burst_nxt;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (stats_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (req0_ready && !(&r_cnt0))
                r_cnt0 <= r_cnt0 + 1'b1;
            if (req1_ready && !(&r_cnt1))
                r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign beat_cnt0 = r_cnt0;
    assign beat_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized and directed bench for fifo_write_arbiter
// with a behavioural reference model and per-producer order scoreboard.

module tb_fifo_write_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_data_in;
    logic [1:0] grant;
`ifdef ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] beat_cnt0;
    logic [15:0] beat_cnt1;
    logic [1:0]  s_cnt0;
    logic [1:0]  s_cnt1;
    logic        d2_r0;
    logic        d2_r1;
    logic        d2_we;
    logic [7:0]  d2_d;
    logic [1:0]  d2_g;
`endif

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(8), .MAX_BURST(MB), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in),
`ifdef ARB_STATS_EN
        .stats_clr(stats_clr), .beat_cnt0(beat_cnt0), .beat_cnt1(beat_cnt1),
`endif
        .grant(grant)
    );

`ifdef ARB_STATS_EN
    fifo_write_arbiter #(.DATA_WIDTH(8), .MAX_BURST(MB), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(d2_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(d2_r1),
        .fifo_full(fifo_full), .fifo_wr_en(d2_we), .fifo_data_in(d2_d),
        .stats_clr(stats_clr), .beat_cnt0(s_cnt0), .beat_cnt1(s_cnt1),
        .grant(d2_g)
    );
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- producers ----------------
    logic [7:0] pq0[$];
    logic [7:0] pq1[$];
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];
    int gap = 0;
    bit full_rand = 0;
    bit acc0 = 0;
    bit acc1 = 0;

    task automatic push0(logic [7:0] b);
        pq0.push_back(b);
        eq0.push_back(b);
    endtask

    task automatic push1(logic [7:0] b);
        pq1.push_back(b);
        eq1.push_back(b);
    endtask

    function automatic void drive();
        if (req0_valid && acc0) begin
            void'(pq0.pop_front());
            req0_valid = 1'b0;
        end
        if (req1_valid && acc1) begin
            void'(pq1.pop_front());
            req1_valid = 1'b0;
        end
        if (!req0_valid && pq0.size() > 0 && $urandom_range(99) >= gap) begin
            req0_valid = 1'b1;
            req0_data  = pq0[0];
        end
        if (!req1_valid && pq1.size() > 0 && $urandom_range(99) >= gap) begin
            req1_valid = 1'b1;
            req1_data  = pq1[0];
        end
        if (full_rand)
            fifo_full = ($urandom_range(99) < 25);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, 0/1 producer; served: beats in current grant.
    int m_own = -1;
    int m_cnt = 0;
    int m_last = 1;
    int m_c0 = 0;
    int m_c1 = 0;
    bit e_r0 = 0;
    bit e_r1 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_own  = -1;
            m_last = 1;
            m_cnt  = 0;
            m_c0   = 0;
            m_c1   = 0;
        end else begin
`ifdef ARB_STATS_EN
            if (stats_clr) begin
                m_c0 = 0;
                m_c1 = 0;
            end else begin
                if (e_r0 && m_c0 < 65535) m_c0++;
                if (e_r1 && m_c1 < 65535) m_c1++;
            end
`endif
            if (m_own < 0) begin
                if (req0_valid && req1_valid) m_own = 1 - m_last;
                else if (req0_valid) m_own = 0;
                else if (req1_valid) m_own = 1;
            end else begin
                bit vo;
                bit vt;
                vo = (m_own == 0) ? req0_valid : req1_valid;
                vt = (m_own == 0) ? req1_valid : req0_valid;
                if (!vo) begin
                    m_last = m_own;
                    m_cnt  = 0;
                    m_own  = vt ? 1 - m_own : -1;
                end else if (!fifo_full) begin
                    m_cnt++;
                    if (m_cnt == MB) begin
                        m_cnt  = 0;
                        m_last = m_own;
                        m_own  = vt ? 1 - m_own : m_own;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    typedef struct packed {
        logic [1:0] g;
        logic       we;
        logic [7:0] d;
        logic       r0;
        logic       r1;
    } ent_t;
    ent_t lg[$];

    logic [1:0] eg;
    logic       ew;
    logic [7:0] ed;
    ent_t       ent;

    always @(negedge clk) begin
        eg = (m_own < 0) ? 2'd0 : (m_own == 0) ? 2'd1 : 2'd2;
        ew = ((m_own == 0 && req0_valid) || (m_own == 1 && req1_valid)) && !fifo_full;
        e_r0 = ew && (m_own == 0);
        e_r1 = ew && (m_own == 1);
        ed = !ew ? 8'h00 : (m_own == 0) ? req0_data : req1_data;
        chk("grant", int'(grant), int'(eg));
        chk("wr_en", int'(fifo_wr_en), int'(ew));
        chk("data", int'(fifo_data_in), int'(ed));
        chk("rdy0", int'(req0_ready), int'(e_r0));
        chk("rdy1", int'(req1_ready), int'(e_r1));
        if (req0_ready) begin
            if (eq0.size() == 0) chk("ord0_extra", 1, 0);
            else chk("ord0", int'(fifo_data_in), int'(eq0.pop_front()));
        end
        if (req1_ready) begin
            if (eq1.size() == 0) chk("ord1_extra", 1, 0);
            else chk("ord1", int'(fifo_data_in), int'(eq1.pop_front()));
        end
`ifdef ARB_STATS_EN
        chk("cnt0", int'(beat_cnt0), m_c0);
        chk("cnt1", int'(beat_cnt1), m_c1);
        chk("scnt0", int'(s_cnt0), (m_c0 > 3) ? 3 : m_c0);
        chk("scnt1", int'(s_cnt1), (m_c1 > 3) ? 3 : m_c1);
`endif
        acc0 = req0_ready;
        acc1 = req1_ready;
        ent.g  = grant;
        ent.we = fifo_wr_en;
        ent.d  = fifo_data_in;
        ent.r0 = req0_ready;
        ent.r1 = req1_ready;
        lg.push_back(ent);
    end

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(int bound);
        for (int i = 0; i < bound &&
             (pq0.size() > 0 || pq1.size() > 0 || req0_valid || req1_valid); i++)
            step();
        chk("drain_timeout", pq0.size() + pq1.size() + int'(req0_valid) + int'(req1_valid), 0);
        repeat (3) step();
    endtask

    logic [7:0] exp2[16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                             8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27};

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        fifo_full  = 1'b0;
`ifdef ARB_STATS_EN
        stats_clr  = 1'b0;
`endif
        step();
        step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_we", int'(fifo_wr_en), 0);
        chk("rst_rdy", int'(req0_ready) + int'(req1_ready), 0);
        reset = 1'b0;
        step();

        // single producer, three beats
        lg.delete();
        push0(8'hA1); push0(8'hB2); push0(8'hC3);
        drive();
        repeat (6) step();
        chk("t1_idle_g", int'(lg[0].g), 0);
        chk("t1_idle_we", int'(lg[0].we), 0);
        chk("t1_d0", int'(lg[1].d), 8'hA1);
        chk("t1_d1", int'(lg[2].d), 8'hB2);
        chk("t1_d2", int'(lg[3].d), 8'hC3);
        for (int i = 1; i <= 3; i++) begin
            chk("t1_g", int'(lg[i].g), 1);
            chk("t1_r0", int'(lg[i].r0), 1);
        end
        chk("t1_r0_after", int'(lg[4].r0), 0);
        chk("t1_g_idle", int'(lg[5].g), 0);

        // both continuous: alternating bursts of four
        do_reset();
        lg.delete();
        for (int i = 0; i < 8; i++) begin
            push0(8'(8'h10 + i));
            push1(8'(8'h20 + i));
        end
        drive();
        repeat (18) step();
        chk("t2_idle", int'(lg[0].we), 0);
        for (int i = 0; i < 16; i++) begin
            chk("t2_we", int'(lg[1+i].we), 1);
            chk("t2_d", int'(lg[1+i].d), int'(exp2[i]));
            chk("t2_g", int'(lg[1+i].g), ((i / 4) % 2 == 0) ? 1 : 2);
        end

        // full stall inside a burst
        do_reset();
        lg.delete();
        for (int i = 0; i < 4; i++) push0(8'(8'h30 + i));
        push1(8'h40);
        drive();
        repeat (3) step();
        fifo_full = 1'b1;
        repeat (2) step();
        fifo_full = 1'b0;
        repeat (5) step();
        chk("t3_d1", int'(lg[1].d), 8'h30);
        chk("t3_d2", int'(lg[2].d), 8'h31);
        for (int i = 3; i <= 4; i++) begin
            chk("t3_stall_we", int'(lg[i].we), 0);
            chk("t3_stall_r0", int'(lg[i].r0), 0);
            chk("t3_stall_g", int'(lg[i].g), 1);
        end
        chk("t3_d3", int'(lg[5].d), 8'h32);
        chk("t3_d4", int'(lg[6].d), 8'h33);
        chk("t3_g4", int'(lg[6].g), 1);
        chk("t3_g_r1", int'(lg[7].g), 2);
        chk("t3_d_r1", int'(lg[7].d), 8'h40);

        // early drop hands over to waiting req1
        lg.delete();
        push0(8'h50); push0(8'h51); push1(8'h5A);
        drive();
        repeat (6) step();
        chk("t4_d50", int'(lg[1].d), 8'h50);
        chk("t4_drop_g", int'(lg[3].g), 1);
        chk("t4_drop_we", int'(lg[3].we), 0);
        chk("t4_g10", int'(lg[4].g), 2);
        chk("t4_d5a", int'(lg[4].d), 8'h5A);

        // req0 served alone, then a tie goes to req1
        lg.delete();
        push0(8'h60); push0(8'h61);
        drive();
        repeat (5) step();
        chk("t4b_idle", int'(lg[4].g), 0);
        lg.delete();
        push0(8'h62); push1(8'h70);
        drive();
        repeat (5) step();
        chk("t4b_tie_g", int'(lg[1].g), 2);
        chk("t4b_tie_d", int'(lg[1].d), 8'h70);
        chk("t4b_next_d", int'(lg[3].d), 8'h62);

        // reset mid-burst
        do_reset();
        for (int i = 0; i < 6; i++) push0(8'(8'h80 + i));
        for (int i = 0; i < 4; i++) push1(8'(8'h90 + i));
        drive();
        step();
        step();
        chk("t5_pre_we", int'(fifo_wr_en), 1);
        reset = 1'b1;
        #1;
        chk("t5_async_we", int'(fifo_wr_en), 0);
        chk("t5_async_r0", int'(req0_ready), 0);
        chk("t5_async_g", int'(grant), 0);
        step();
        step();
        reset = 1'b0;
        lg.delete();
        repeat (3) step();
        chk("t5_first_g", int'(lg[1].g), 1);
        chk("t5_first_d", int'(lg[1].d), 8'h81);
        drain(200);

`ifdef ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) push0(8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) push1(8'(8'hD0 + i));
        drive();
        drain(200);
        chk("t6_cnt0", int'(beat_cnt0), 5);
        chk("t6_cnt1", int'(beat_cnt1), 3);
        chk("t6_sat0", int'(s_cnt0), 3);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("t6_clr0", int'(beat_cnt0), 0);
        chk("t6_clr1", int'(beat_cnt1), 0);
`endif

        // randomized traffic with random full
        do_reset();
        gap = 40;
        full_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            push0(8'($urandom));
            push1(8'($urandom));
        end
        drive();
        drain(5000);
        full_rand = 1'b0;
        fifo_full = 1'b0;
        repeat (3) step();
        chk("rand_left0", eq0.size(), 0);
        chk("rand_left1", eq1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that lets two producers share the single write port of the 8-bit FIFO (wr_en / data_in / full).
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time, for bursts of up to MAX_BURST beats.
- It drives the FIFO write port directly and respects the FIFO's full flag.
- It sits between the producer blocks and the FIFO instance.

Parameters:
- DATA_WIDTH, 8, width of producer data and FIFO data_in.
- MAX_BURST, 4, maximum beats per grant before the grant is offered to the other requester (legal range 1..16).
- CNT_WIDTH, 16, width of the statistics counters (used only with ARB_STATS_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  producer 0 has a beat.
- req0_data  input  DATA_WIDTH  producer 0 beat data.
- req0_ready  output  1  producer 0 beat accepted this cycle.
- req1_valid  input  1  producer 1 has a beat.
- req1_data  input  DATA_WIDTH  producer 1 beat data.
- req1_ready  output  1  producer 1 beat accepted this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- grant  output  2  registered one-hot grant; bit0 = req0, bit1 = req1, 00 = idle.
- stats_clr  input  1  synchronous clear of the statistics counters (ARB_STATS_EN only).
- beat_cnt0  output  CNT_WIDTH  accepted beats from req0 (ARB_STATS_EN only).
- beat_cnt1  output  CNT_WIDTH  accepted beats from req1 (ARB_STATS_EN only).

Behaviour:
- States: IDLE, GNT0, GNT1. The grant output equals the state encoding: 00, 01, 10.
- Internal registers:
  - last: index of the requester served most recently.
  - burst_cnt: beats in the current grant, width clog2(MAX_BURST)+1.
- Reset (asynchronous, takes effect immediately and mid-operation):
  - state = IDLE, grant = 00.
  - last = 1, so req0 wins the first tie.
  - burst_cnt = 0; stats counters = 0.
  - Every output is 0 while reset is high.
- Producer rule: once valid is asserted, the producer holds valid and data stable until it sees ready. A valid low while granted therefore means the producer has no more data.
- Beat condition in GNTx: beat = reqx_valid && !fifo_full.
  - Outputs are combinational from the registered state: fifo_wr_en = beat; reqx_ready = beat; fifo_data_in = reqx_data.
  - In IDLE, or when there is no beat: fifo_wr_en = 0, both readys = 0, fifo_data_in = 0.
- IDLE transitions:
  - Both valid: go to GNT of the requester != last.
  - One valid: go to its GNT.
  - Neither valid: stay in IDLE.
  - No transfer occurs in the IDLE cycle, so the first beat has 1 cycle of latency after valid.
- GNTx transitions, evaluated each cycle:
  - fifo_full = 1 with reqx_valid = 1: stall. Hold the state; burst_cnt unchanged.
  - Beat, and burst_cnt+1 < MAX_BURST: stay; burst_cnt += 1.
  - Beat, and burst_cnt+1 == MAX_BURST (burst end): last = x, burst_cnt = 0. Next state is GNT(other) if the other requester is valid, else GNTx if reqx is still valid, else IDLE. There is no bubble between back-to-back bursts.
  - reqx_valid = 0: last = x, burst_cnt = 0. Next state is GNT(other) if the other requester is valid, else IDLE.
- MAX_BURST = 1: the grant alternates on every beat whenever both requesters are valid.
- At most one ready is high in any cycle. fifo_wr_en is never high while fifo_full = 1.
- Throughput: 1 beat/cycle while granted and the FIFO is not full.

Optional Feature:
ARB_STATS_EN
- Defined:
  - The ports stats_clr, beat_cnt0 and beat_cnt1 exist.
  - Each counter increments on every accepted beat of its requester.
  - Counters saturate at all-ones.
  - stats_clr = 1 clears both counters on the next edge; clear has priority over increment.
  - Counters reset to 0.
- Undefined: those ports and the counter logic are absent. Arbitration behaviour is identical.

Test Plan:
1. Reset, then req0 alone offers A1, B2, C3 (MAX_BURST=4), FIFO not full.
   - Required: grant = 01 one cycle after valid.
   - Required: fifo_wr_en high for 3 consecutive cycles with data A1, B2, C3; req0_ready is high on exactly those cycles.
   - Required: grant returns to 00 after valid drops.
2. Both requesters continuously valid, req0 data 10..17, req1 data 20..27.
   - Required: 4 beats from req0 (10–13), then 4 from req1 (20–23), then 14–17, then 24–27.
   - Required: no idle cycle between bursts.
3. During a req0 burst, fifo_full held high for 2 cycles after the 2nd beat.
   - Required: fifo_wr_en = 0 and req0_ready = 0 for those 2 cycles; grant stays 01.
   - Required: beats 3 and 4 complete after full drops, and req1 is granted only after beat 4.
4. req0 drops valid after 2 beats while req1 is valid with 5A.
   - Required: grant goes 01 -> 10 on the next edge; 5A is written the cycle after.
   - Required: a following tie is won by req1 (last = 0).
5. Reset pulsed mid-burst.
   - Required: fifo_wr_en, readys and grant are 0 immediately, without waiting for a clock edge.
   - Required: after release with both valid, req0 is granted first.
6. With ARB_STATS_EN: 5 beats from req0 and 3 from req1.
   - Required: beat_cnt0 = 5, beat_cnt1 = 3.
   - Required: stats_clr pulse clears both to 0.
   - Required: with CNT_WIDTH = 2, 5 beats saturate at 3.
